mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Lets NUM_CH cache clients take turns on one slow line-wide memory port.
// One memory transaction is in flight at a time. The winner's operation,
// address and write line are captured when it is granted. The memory side
// is then driven only from that captured copy.
//
// Handshake: a client raises ch_read[i] or ch_write[i] (both = write) and
// holds it, together with its ch_addr/ch_wdata slice, until ch_ready[i]
// pulses. ch_ready[i] is a one-cycle completion pulse, driven
// combinationally in the BUSY cycle in which mem_ready is high. mem_read or
// mem_write stays asserted, with a stable address and line, until that
// mem_ready cycle. Read data is ch_rdata, a plain copy of mem_rdata that is
// meaningful in the ready cycle.
//
// Build option: define ARB_FIXED_PRIORITY_EN for fixed priority (lowest
// index wins). The default build uses round-robin.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   ch_read/ch_write   [NUM_CH]          per-client requests
//   ch_addr            [NUM_CH*ADDR_W]   client line addresses, packed
//   ch_wdata           [NUM_CH*LINE_W]   client write lines, packed
//   ch_rdata           [LINE_W]          read line broadcast to all clients
//   ch_ready           [NUM_CH]          one-hot completion pulse
//   mem_read/mem_write                   slow-memory requests
//   mem_addr/mem_wdata                   slow-memory address / write line
//   mem_rdata/mem_ready                  slow-memory read line / completion
//   state_dbg          [2]               FSM state (0 IDLE, 1 BUSY, 2 DONE)
module mem_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  output logic [LINE_W-1:0]          ch_rdata,
  output logic [NUM_CH-1:0]          ch_ready,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic [LINE_W-1:0]          mem_rdata,
  input  logic                       mem_ready,
  output logic [1:0]                 state_dbg
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;

  logic [NUM_CH-1:0]   req;
  logic [IDX_W-1:0]    win_idx;

  assign req = ch_read | ch_write;

  // Winner selection; only consulted in IDLE when some client requests.
`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_idx = '0;
    cand    = '0;
    // Walk from the top so the lowest requesting index is written last.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = IDX_W'(i);
      if (req[cand]) win_idx = cand;
    end
  end
`else
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    int               idx;
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    idx     = 0;
    // Start one past the previous winner and wrap around.
    for (int k = 1; k <= NUM_CH; k++) begin
      idx  = (int'(last_grant_q) + k) % NUM_CH;
      cand = IDX_W'(idx);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end
`endif

  // Next-state and capture logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d      = BUSY;
          grant_d      = win_idx;
          last_grant_d = win_idx;
          op_write_d   = ch_write[win_idx];
          addr_d       = ch_addr[win_idx*ADDR_W +: ADDR_W];
          wdata_d      = ch_wdata[win_idx*LINE_W +: LINE_W];
        end
      end
      BUSY: begin
        // Client request lines are ignored here: a dropped request still
        // completes and still gets its ready pulse.
        if (mem_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_CH - 1);
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Completion pulse exists only in the BUSY cycle that sees mem_ready.
  always_comb begin
    ch_ready = '0;
    if (state_q == BUSY && mem_ready) ch_ready[grant_q] = 1'b1;
  end

  assign mem_read  = (state_q == BUSY) && !op_write_q;
  assign mem_write = (state_q == BUSY) &&  op_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ch_rdata  = mem_rdata;
  assign state_dbg = state_q;

endmodule
